// File: rtl/canny_pkg.sv
// Shared types and default geometry for the canny pixel feeder.
package canny_pkg;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;
  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

endpackage

// File: rtl/canny_feeder_skid.sv
// Two-entry pixel+flag buffer absorbing the frame-RAM read latency; zero-latency head, pops on out_valid&out_ready.
// No input-side backpressure: the producer must never push into a full buffer without a same-cycle pop.
module canny_feeder_skid
  import canny_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic [1:0]       count
);

  localparam int ENT_W = PIX_W + 3;

  logic [ENT_W-1:0] ent0, ent1, in_ent;
  logic [1:0]       cnt;
  logic             pop;

  assign in_ent    = {in_pixel, in_sof, in_eol, in_eof};
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  // Head is forced to zero when empty so idle outputs read as all-zero.
  assign {out_pixel, out_sof, out_eol, out_eof} = out_valid ? ent0 : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({in_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= in_ent;
          else             ent1 <= in_ent;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= in_ent;
          end else begin
            ent0 <= ent1;
            ent1 <= in_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/canny_pixel_feeder.sv
// Streams a frame from frame RAM in raster order with sof/eol/eof; start->out_valid 3 cycles, 1 pixel/cycle, reads throttled by buffer credit.
// Define CANNY_FEEDER_CONT_EN to stream frames back-to-back after one start.
module canny_pixel_feeder
  import canny_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  feeder_state_t    state, state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ADDR_W-1:0] addr;
  logic             pend;
  pix_flags_t       pend_flags, rd_flags;
  logic [1:0]       buf_cnt;
  logic [2:0]       occ;
  logic             kill, xfer, last_col, last_rd;

  assign kill     = reset | abort;
  assign xfer     = out_valid & out_ready;
  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_rd  = last_col && (row == ROW_W'(IMG_H - 1));

  // Credit: entries left after this cycle's pop plus the read landing this cycle.
  assign occ       = {1'b0, buf_cnt} + {2'b00, pend} - {2'b00, xfer};
  assign mem_rd_en = (state == RUN) && !kill && (occ < 3'd2);
  assign mem_addr  = addr;

  assign rd_flags.sof = (addr == '0);
  assign rd_flags.eol = last_col;
  assign rd_flags.eof = last_rd;

  assign busy       = (state == RUN) || (state == DRAIN);
  assign frame_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (mem_rd_en && last_rd) state_nxt = DRAIN;
      DRAIN: if (xfer && out_eof) state_nxt = DONE;
`ifdef CANNY_FEEDER_CONT_EN
      DONE:  state_nxt = RUN;
`else
      DONE:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Counters return to zero on the last read, so a restart always begins at address 0.
  always_ff @(posedge clk) begin
    if (kill) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (mem_rd_en) begin
      if (last_col) begin
        col <= '0;
        row <= last_rd ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      addr <= last_rd ? '0 : addr + ADDR_W'(1);
    end
  end

  // Clearing pend on abort/reset drops any read data still in flight.
  always_ff @(posedge clk) begin
    if (kill) begin
      pend       <= 1'b0;
      pend_flags <= '0;
    end else begin
      pend <= mem_rd_en;
      if (mem_rd_en) pend_flags <= rd_flags;
    end
  end

  canny_feeder_skid #(
    .PIX_W(PIX_W)
  ) u_skid (
    .clk      (clk),
    .clear    (kill),
    .in_valid (pend),
    .in_pixel (mem_rd_data),
    .in_sof   (pend_flags.sof),
    .in_eol   (pend_flags.eol),
    .in_eof   (pend_flags.eof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .out_eof  (out_eof),
    .count    (buf_cnt)
  );

endmodule

// File: tb/tb_canny_pixel_feeder.sv
// Scoreboard bench for canny_pixel_feeder on a 4x3 image with RAM[a]=a+16.
module tb_canny_pixel_feeder;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset, start, abort, out_ready;
  logic       mem_rd_en, out_valid, out_sof, out_eol, out_eof, busy, frame_done;
  logic [3:0] mem_addr;
  logic [7:0] mem_rd_data, out_pixel;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   rd_cnt = 0, xf_cnt = 0, rd_base = 0, xf_base = 0, done_cnt = 0;
  int   mode = 0;
  logic hold_vld = 1'b0, prev_eof = 1'b0, prev_kill = 1'b0, xfer;
  exp_t held, got, e;

  always #5 clk = ~clk;

  canny_pixel_feeder #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Frame RAM with one-cycle read latency; garbage on the bus when not reading.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? (8'(mem_addr) + 8'd16) : 8'($urandom);

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_t x;
    for (int a = 0; a < N; a++) begin
      x.pix = 8'(a + 16);
      x.sof = (a == 0);
      x.eol = (a % W) == (W - 1);
      x.eof = (a == N - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    push_frame();
    rd_base = rd_cnt;
    xf_base = xf_cnt;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      cyc();
      n++;
    end
    cyc();
    cyc();
    chk(name, (n < 3000) ? exp_q.size() : 999, 0);
  endtask

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      cyc();
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected pixels on transfers and checks reads, stalls and frame_done.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_vld  = 1'b0;
        prev_eof  = 1'b0;
        prev_kill = 1'b1;
      end else begin
        got = '{out_pixel, out_sof, out_eol, out_eof};
        if (hold_vld) chk("stall_hold", {out_valid, got}, {1'b1, held});
        xfer = out_valid && out_ready;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer actual=%0d required=none", out_pixel);
          end else begin
            e = exp_q.pop_front();
            chk("pixel_flags", got, e);
          end
          xf_cnt++;
`ifdef CANNY_FEEDER_CONT_EN
          if (out_eof && !abort) push_frame();
`endif
        end
        if (mem_rd_en) begin
          chk("rd_addr", mem_addr, (rd_cnt - rd_base) % N);
          chk("outstanding_le2", (rd_cnt - rd_base + 1 - (xf_cnt - xf_base)) <= 2, 1);
          rd_cnt++;
        end
        if (frame_done || (prev_eof && !prev_kill))
          chk("frame_done", frame_done, prev_eof && !prev_kill);
        if (frame_done) done_cnt++;
        prev_eof  = xfer && out_eof;
        prev_kill = abort;
        hold_vld  = out_valid && !out_ready && !abort;
        held      = got;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (3) cyc();
    chk("reset_outputs", {mem_rd_en, mem_addr, out_valid, out_pixel, out_sof, out_eol,
                          out_eof, busy, frame_done}, 0);
    reset = 1'b0;
    cyc();

`ifdef CANNY_FEEDER_CONT_EN
    d0 = done_cnt;
    do_start();
    n = 0;
    while (xf_cnt - xf_base < 2 * N && n < 300) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    exp_q.delete();
    chk("cont_xfers", xf_cnt - xf_base, 2 * N);
    chk("cont_done_pulses", done_cnt - d0, 2);
    chk("cont_abort_state", {busy, out_valid}, 0);
`else
    // Latency and full-rate streaming.
    start = 1'b1;
    push_frame();
    rd_base = rd_cnt;
    xf_base = xf_cnt;
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("lat_c1_read", {mem_rd_en, mem_addr, out_valid}, {1'b1, 4'd0, 1'b0});
    @(negedge clk);
    chk("lat_c2_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_c3_valid", {out_valid, out_pixel, out_sof}, {1'b1, 8'd16, 1'b1});
    cyc();
    n = 0;
    while (xf_cnt - xf_base < N && n < 100) begin
      cyc();
      n++;
    end
    chk("throughput_cycles", n, N - 1);
    wait_idle("frame_full_rate");

    mode = 1;
    do_start();
    wait_idle("frame_toggle_ready");

    // Downstream stalled from the start: only two reads may issue.
    mode = 3;
    cyc();
    do_start();
    repeat (19) cyc();
    chk("hold_reads", rd_cnt - rd_base, 2);
    chk("hold_head", {out_valid, out_pixel}, {1'b1, 8'd16});
    mode = 0;
    wait_idle("frame_after_hold");

    // Abort on the 5th transfer.
    d0 = done_cnt;
    do_start();
    n = 0;
    while (xf_cnt - xf_base < 4 && n < 100) begin
      cyc();
      n++;
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    exp_q.delete();
    chk("abort_state", {busy, out_valid, frame_done}, 0);
    chk("abort_xfers", xf_cnt - xf_base, 5);
    repeat (4) cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    do_start();
    wait_idle("frame_after_abort");

    // A second start mid-frame must not restart addressing.
    do_start();
    repeat (4) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle("frame_restart_ignored");

    mode = 2;
    do_start();
    wait_idle("frame_random_ready_a");
    do_start();
    wait_idle("frame_random_ready_b");
    mode = 0;

    // Reset mid-frame.
    do_start();
    repeat (6) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    chk("midframe_reset_outputs", {mem_rd_en, mem_addr, out_valid, out_pixel, out_sof,
                                   out_eol, out_eof, busy, frame_done}, 0);
    repeat (2) cyc();
    do_start();
    wait_idle("frame_after_reset");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/canny_pixel_feeder.md
CANNY_PIXEL_FEEDER -- requirements
Module: canny_pixel_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 320: pixels per row.
REQ-002 SHALL have parameter IMG_H, default 240: rows per frame.
REQ-003 SHALL have parameter PIX_W, default 8: grayscale pixel width.
REQ-004 SHALL have parameter ADDR_W, default 17: frame-RAM address width, and ADDR_W SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 SHALL have ports, one per line below (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request; ignored while busy.
- abort  in  1  synchronous frame cancel.
- mem_rd_en  out  1  frame-RAM read strobe.
- mem_addr  out  ADDR_W  raster address = row*IMG_W+col.
- mem_rd_data  in  PIX_W  RAM data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  pixel available.
- out_ready  in  1  downstream (canny_advanced input) accepts.
- out_pixel  out  PIX_W  pixel value.
- out_sof  out  1  first pixel of frame.
- out_eol  out  1  last pixel of a row.
- out_eof  out  1  last pixel of frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the eof transfer.

Function
REQ-006 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1; once out_valid is high, out_pixel and the flags SHALL hold until the transfer occurs.
REQ-007 FSM states SHALL be IDLE, RUN, DRAIN and DONE: IDLE->RUN on start; RUN->DRAIN after the read of address IMG_W*IMG_H-1 issues; DRAIN->DONE when the eof transfer occurs; DONE->IDLE after 1 cycle.
REQ-008 frame_done SHALL be high only in DONE.
REQ-009 busy SHALL be high in RUN and DRAIN.
REQ-010 Reads SHALL be issued in raster order from address 0 to IMG_W*IMG_H-1, with no address skipped or repeated.
REQ-011 A 2-entry output buffer SHALL absorb the read latency; a read SHALL issue only when (buffered entries + in-flight reads) < 2, so no data is ever lost or overwritten.
REQ-012 Latency: with start high in cycle 0 and out_ready=1 held high, mem_rd_en/addr 0 SHALL appear in cycle 1 and out_valid in cycle 3.
REQ-013 Throughput SHALL be 1 pixel/cycle with out_ready held high.
REQ-014 out_sof SHALL be set for col=0,row=0; out_eol for col=IMG_W-1; out_eof for the last pixel, together with out_eol.
REQ-015 The col and row counters SHALL wrap col IMG_W-1->0 and increment row on that wrap.
REQ-016 start in any state other than IDLE SHALL be ignored.
REQ-017 abort SHALL have priority over start; in any state it SHALL next cycle give state IDLE, an empty buffer, counters 0, out_valid=0, and no frame_done.
REQ-018 In-flight read data arriving after an abort SHALL be discarded.

Reset
REQ-019 While reset=1, next edge: state IDLE, counters 0, buffer empty, mem_rd_en=0, mem_addr=0, out_valid=0, out_pixel=0, all flags 0, busy=0, frame_done=0.
REQ-020 reset SHALL take priority over abort and start.
REQ-021 reset mid-frame SHALL behave as abort (REQ-017, REQ-018).

Configuration
REQ-022 With CANNY_FEEDER_CONT_EN defined, DONE SHALL go directly to RUN, restarting at address 0, so frames stream back-to-back until abort or reset.
REQ-023 With CANNY_FEEDER_CONT_EN defined, frame_done SHALL still pulse once per frame.
REQ-024 Without CANNY_FEEDER_CONT_EN, each frame SHALL require a start pulse.

Structure
REQ-025 Package canny_pkg SHALL hold the FSM state typedef (IDLE/RUN/DRAIN/DONE) and the default IMG_W/IMG_H/PIX_W constants.
REQ-026 The 2-entry output buffer SHALL be sub-module canny_feeder_skid, which carries the pixel plus the sof/eol/eof flags.

Verification (IMG_W=4, IMG_H=3, RAM[a]=a+16)
REQ-027 Pulse start with out_ready=1 -> out_valid in cycle 3; 12 transfers with values 16..27 consecutive; sof on 16; eol on 19, 23 and 27; eof on 27; frame_done exactly 1 cycle after the eof transfer.
REQ-028 Toggle out_ready 1/0 each cycle -> same 12 values in order, none dropped or duplicated, outputs stable while stalled, at most 2 reads outstanding.
REQ-029 Hold out_ready=0 for 20 cycles after start -> exactly 2 reads issued (addr 0, 1), out_pixel=16 held; on release, the stream completes correctly.
REQ-030 Assert abort at the 5th transfer -> next cycle busy=0 and out_valid=0, no frame_done; a new start replays from 16 with sof.
REQ-031 start again mid-frame -> ignored, no address restart; assert reset mid-frame -> all outputs 0 next cycle.
REQ-032 With CANNY_FEEDER_CONT_EN, one start -> 24 consecutive transfers 16..27,16..27, with frame_done pulsing twice.
